// File: rtl/lfsr_gen.sv
// Maximal-length LFSR with Fibonacci/Galois modes, seed load,
// MISR signature compression and a period counter.
module lfsr_gen #(
  parameter int              WIDTH = 16,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] SEED = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             misr_en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             period_done,
  output logic             zero_err
);

  // Fibonacci tap positions as bit masks (tap t -> bit t-1)
  function automatic logic [31:0] fib_taps(input int w);
    case (w)
      4:       fib_taps = 32'h0000_000C;
      8:       fib_taps = 32'h0000_00B8;
      16:      fib_taps = 32'h0000_B400;
      24:      fib_taps = 32'h00E1_0000;
      32:      fib_taps = 32'h8020_0003;
      default: fib_taps = 32'h0;
    endcase
  endfunction

  // Galois mask: low-order polynomial terms including x^0
  function automatic logic [31:0] gal_mask(input int w);
    case (w)
      4:       gal_mask = 32'h0000_0009;
      8:       gal_mask = 32'h0000_0071;
      16:      gal_mask = 32'h0000_6801;
      24:      gal_mask = 32'h00C2_0001;
      32:      gal_mask = 32'h0040_0007;
      default: gal_mask = 32'h0;
    endcase
  endfunction

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 ||
        WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
    $error("lfsr_gen: unsupported WIDTH %0d", WIDTH);
  end

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end

  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("lfsr_gen: MODE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] TAPS    = WIDTH'(fib_taps(WIDTH));
  localparam logic [WIDTH-1:0] MASK    = WIDTH'(gal_mask(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_PRE = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam bit               GALOIS  = (MODE == 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] step_v;
  logic             pd_q, pd_d;
  logic             ze_q, ze_d;
  logic             d_in;
  logic             fib_fb;
  logic             gal_m;

  assign d_in   = misr_en & din;
  assign fib_fb = (^(q_q & TAPS)) ^ d_in;
  assign gal_m  = q_q[WIDTH-1] ^ d_in;

  always_comb begin
    step_v = {q_q[WIDTH-2:0], fib_fb};
    if (GALOIS) begin
      step_v = {q_q[WIDTH-2:0], 1'b0} ^ (gal_m ? MASK : '0);
    end
  end

  // load outranks en; a zero seed is replaced by 1 and flagged
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    pd_d  = 1'b0;
    ze_d  = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (seed_in == '0) begin
        q_d  = ONE;
        ze_d = 1'b1;
      end else begin
        q_d = seed_in;
      end
    end else if (en) begin
      q_d   = step_v;
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      pd_d  = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= SEED;
      cnt_q <= '0;
      pd_q  <= 1'b0;
      ze_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      pd_q  <= pd_d;
      ze_q  <= ze_d;
    end
  end

  assign q           = q_q;
  assign bit_out     = q_q[WIDTH-1];
  assign period_done = pd_q;
  assign zero_err    = ze_q;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter: WIDTH, default 16, register length; legal values 4, 8, 16, 24, 32 only; any other value shall fail elaboration.
REQ-002 Parameter: MODE, default 0, 0 = Fibonacci, 1 = Galois.
REQ-003 Parameter: SEED, default all-ones of WIDTH, reset state; SEED = 0 shall fail elaboration.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  advance the register one step this cycle.
REQ-007 load  input  1  load seed_in this cycle.
REQ-008 seed_in  input  WIDTH  seed value for load.
REQ-009 misr_en  input  1  signature mode; XOR din into the feedback.
REQ-010 din  input  1  serial data compressed while misr_en=1.
REQ-011 q  output  WIDTH  current register state.
REQ-012 bit_out  output  1  q[WIDTH-1], serial PRBS output.
REQ-013 period_done  output  1  one-cycle pulse when the step counter completes 2^WIDTH-1 steps.
REQ-014 zero_err  output  1  one-cycle pulse when a zero seed load is rejected.

Function
REQ-015 Polynomial taps (Fibonacci bit positions, 1-based) shall be: 4:(4,3); 8:(8,6,5,4); 16:(16,14,13,11); 24:(24,23,22,17); 32:(32,22,2,1).
REQ-016 Fibonacci step: q <= {q[WIDTH-2:0], fb}; fb = XOR of the tapped bits, XOR din when misr_en=1.
REQ-017 Galois step: q <= {q[WIDTH-2:0],0} ^ (m ? MASK : 0); m = q[WIDTH-1] ^ (misr_en & din); MASK = low-order polynomial terms including x^0 (WIDTH=16: 0x6801).
REQ-018 Priority shall be reset > load > en; with all three low, q, the counter and all outputs hold, except pulses, which go to 0.
REQ-019 load with seed_in != 0: q <= seed_in, step counter <= 0, no step that cycle, even if en=1.
REQ-020 load with seed_in = 0: q <= 1, step counter <= 0, zero_err = 1 next cycle.
REQ-021 Step counter is WIDTH bits wide, increments on each en step (not on load), and wraps to 0 after reaching 2^WIDTH-1.
REQ-022 period_done shall be 1 in the cycle after the step that brings the counter to 2^WIDTH-1; asserted in both modes and regardless of misr_en.
REQ-023 With misr_en=0, q after exactly 2^WIDTH-1 steps from any nonzero load shall equal the loaded value (maximal length).
REQ-024 q shall never become all-zero with misr_en=0; with misr_en=1 an all-zero state is allowed; the next steps then shift din in.
REQ-025 bit_out shall be combinational from q, zero added latency; all other outputs registered.
REQ-026 The block shall need no multi-cycle paths; one step per clk when en=1.

Reset
REQ-027 On reset=1 at a rising edge: q = SEED, step counter = 0, period_done = 0, zero_err = 0, all in the following cycle.
REQ-028 reset asserted mid-sequence shall discard the current state and counter; en/load in the same cycle are ignored.
REQ-029 After reset deassertion, the first step occurs on the first edge with en=1.

Verification
REQ-030 WIDTH=16, MODE=0, reset, en=1: q = 0xFFFF -> 0xFFFE -> 0xFFFC; bit_out = 1 for the first 15 steps.
REQ-031 WIDTH=16, MODE=1, reset, en=1: q = 0xFFFF -> 0x97FF after one step.
REQ-032 WIDTH=4, both modes, load 4'h1, en=1 for 15 cycles: 15 distinct nonzero states, q = 4'h1 again, period_done pulses exactly once after step 15.
REQ-033 load seed_in = 0 with en=1: q = 1, counter = 0, zero_err single pulse; the next en step follows from state 1.
REQ-034 WIDTH=8, en toggled randomly, reset pulsed mid-run, load and en asserted together: q holds when en=0; reset yields 0xFF; load wins over en; the sequence matches the reference polynomial model.
REQ-035 WIDTH=16, misr_en=1, 100-bit din stream: two runs with identical streams give identical signatures; a single flipped din bit gives a different q.
